// File: rtl/range_pkg.sv
// rtl/range_pkg.sv - shared ASCII constants, bit-state enum and hex digit encoder
package range_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_E  = 8'h45;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
    logic [7:0] code;
    if (nibble < 4'd10) code = 8'h30 + {4'h0, nibble};
    else                code = 8'h37 + {4'h0, nibble};
    return code;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer; RANGE_TX_PARITY_EN adds an even-parity bit (8E1)
// ready is also high in the last stop-bit cycle so the next byte follows with no idle gap.
module uart_tx_byte
  import range_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shreg, shreg_n;
  logic           tx_n;
  logic           bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = START;
          shreg_n = data;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef RANGE_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
`ifdef RANGE_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (start) begin
            state_n = START;
            shreg_n = data;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;

    // tx is registered from the next state so the line changes on the same edge as the state
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[bit_n];
`ifdef RANGE_TX_PARITY_EN
      PARITY:  tx_n = ^shreg_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end

endmodule

// File: rtl/range_uart_reporter.sv
// rtl/range_uart_reporter.sv - sends each range result as a hex/'E' ASCII line ending CR LF
// Frame format follows uart_tx_byte (RANGE_TX_PARITY_EN selects 8E1 instead of 8N1).
module range_uart_reporter
  import range_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 87
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_range,
  input  logic             res_error,
  input  logic             ovr_clr,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int NCHARS = WIDTH / 4;
  localparam int IDX_W  = $clog2(NCHARS + 2);
  localparam logic [IDX_W-1:0] IDX_CR     = IDX_W'(NCHARS);
  localparam logic [IDX_W-1:0] IDX_LAST_N = IDX_W'(NCHARS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST_E = IDX_W'(2);

  logic [WIDTH-1:0] hold_range;
  logic             hold_err;
  logic [IDX_W-1:0] char_idx;
  logic             ser_start, ser_ready;
  logic [7:0]       ser_data;
  logic             start_msg, advance, at_last;

  function automatic logic [7:0] char_at(input logic [WIDTH-1:0] r, input logic e,
                                         input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] sh;
    logic [7:0]       c;
    int               sa;
    sh = '0;
    sa = 0;
    if (e) begin
      if (idx == '0)              c = ASCII_E;
      else if (idx == IDX_W'(1))  c = ASCII_CR;
      else                        c = ASCII_LF;
    end else if (idx < IDX_CR) begin
      sa = 4 * (NCHARS - 1 - int'(idx));
      sh = r >> sa;
      c  = hex_to_ascii(sh[3:0]);
    end else if (idx == IDX_CR) begin
      c = ASCII_CR;
    end else begin
      c = ASCII_LF;
    end
    return c;
  endfunction

  assign start_msg = res_valid && !busy;
  // while busy the serializer is only ready in the final cycle of a stop bit
  assign advance   = busy && ser_ready;
  assign at_last   = (char_idx == (hold_err ? IDX_LAST_E : IDX_LAST_N));
  assign ser_start = start_msg || (advance && !at_last);
  assign ser_data  = start_msg ? char_at(res_range, res_error, '0)
                               : char_at(hold_range, hold_err, char_idx + 1'b1);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ser_start),
    .data  (ser_data),
    .tx    (tx),
    .ready (ser_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_range <= '0;
      hold_err   <= 1'b0;
      char_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_msg) begin
        hold_range <= res_range;
        hold_err   <= res_error;
        char_idx   <= '0;
        busy       <= 1'b1;
      end else if (advance) begin
        if (at_last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          char_idx <= char_idx + 1'b1;
        end
      end
      if (res_valid && busy) overrun <= 1'b1;
      else if (ovr_clr)      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_range_uart_reporter.sv
// tb/tb_range_uart_reporter.sv - directed + random bench with line-level reference model and UART decoder
module tb_range_uart_reporter;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
`ifdef RANGE_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             res_valid = 1'b0;
  logic [WIDTH-1:0] res_range = '0;
  logic             res_error = 1'b0;
  logic             ovr_clr = 1'b0;
  logic             tx, busy, done, overrun;

  int tests = 0;
  int fails = 0;

  range_uart_reporter #(
    .WIDTH(WIDTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_range(res_range),
    .res_error(res_error), .ovr_clr(ovr_clr), .tx(tx), .busy(busy),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected tx level for every future cycle of the accepted line
  bit         mq[$];
  logic       m_done = 1'b0;
  logic       m_ovr  = 1'b0;
  logic [7:0] exp_bytes[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_lit[$];

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction

  task automatic push_char(input logic [7:0] c);
    bit frame[$];
    exp_bytes.push_back(c);
    frame.push_back(1'b0);
    for (int i = 0; i < 8; i++) frame.push_back(c[i]);
    if (FBITS == 11) frame.push_back(^c);
    frame.push_back(1'b1);
    foreach (frame[i]) for (int k = 0; k < CPB; k++) mq.push_back(frame[i]);
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    bit was_busy;
    if (!rst_n) begin
      mq.delete();
      m_done = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      was_busy = (mq.size() > 0);
      m_done = 1'b0;
      if (was_busy) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
      if (res_valid && was_busy) m_ovr = 1'b1;
      else if (ovr_clr)          m_ovr = 1'b0;
      if (res_valid && !was_busy) begin
        if (res_error) push_char(8'h45);
        else for (int i = WIDTH / 4 - 1; i >= 0; i--) push_char(hexc(res_range[4*i +: 4]));
        push_char(8'h0D);
        push_char(8'h0A);
      end
    end
  end

  always @(negedge clk) begin
    chk("tx", tx, (mq.size() > 0) ? mq[0] : 1'b1);
    chk("busy", busy, mq.size() > 0);
    chk("done", done, m_done);
    chk("overrun", overrun, m_ovr);
  end

  // Independent UART receiver on the tx pin
  logic rx_abort = 1'b0;
  always @(negedge rst_n) rx_abort = 1'b1;

  initial begin : decoder
    logic [7:0] rb;
    logic       rp;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        rx_abort = 1'b0;
        repeat (CPB + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rb[i] = tx;
          if (i < 7) repeat (CPB) @(negedge clk);
        end
        rp = 1'b0;
        if (FBITS == 11) begin
          repeat (CPB) @(negedge clk);
          rp = tx;
        end
        repeat (CPB) @(negedge clk);
        if (!rx_abort) begin
          if (FBITS == 11) chk("even_parity", ^{rb, rp}, 0);
          chk("stop_bit", tx, 1);
          rx_q.push_back(rb);
        end
      end
    end
  end

  task automatic pulse(input logic [7:0] r, input logic e);
    res_range = r;
    res_error = e;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) chk("idle_timeout", n, 0);
  endtask

  // Compares decoded line and model bytes against the literal in exp_lit
  task automatic chk_rx(input string nm);
    chk({nm, "_rx_count"}, rx_q.size(), exp_lit.size());
    chk({nm, "_model_count"}, exp_bytes.size(), exp_lit.size());
    foreach (exp_lit[i]) begin
      chk({nm, "_rx_byte"}, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_lit[i]);
      chk({nm, "_model_byte"}, (i < exp_bytes.size()) ? exp_bytes[i] : 8'hxx, exp_lit[i]);
    end
    rx_q.delete();
    exp_bytes.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_overrun", overrun, 0);

    pulse(8'h3A, 1'b0);
    wait_idle(n);
    chk("len_3a", n, 4 * FBITS * CPB);
    chk("done_3a", done, 1);
    @(negedge clk);
    chk("done_3a_single", done, 0);
    exp_lit = {8'h33, 8'h41, 8'h0D, 8'h0A};
    chk_rx("line_3a");

    pulse(8'hFF, 1'b1);
    wait_idle(n);
    chk("len_err", n, 3 * FBITS * CPB);
    chk("done_err", done, 1);
    exp_lit = {8'h45, 8'h0D, 8'h0A};
    chk_rx("line_err");

    pulse(8'hC5, 1'b0);
    repeat (49) @(negedge clk);
    pulse(8'h77, 1'b0);
    chk("ovr_set", overrun, 1);
    wait_idle(n);
    chk("ovr_sticky", overrun, 1);
    exp_lit = {8'h43, 8'h35, 8'h0D, 8'h0A};
    chk_rx("line_ovr");
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);

    pulse(8'hC5, 1'b0);
    repeat (10) @(negedge clk);
    ovr_clr = 1'b1;
    pulse(8'h11, 1'b0);
    ovr_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    wait_idle(n);
    chk_rx("line_setwins");
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;

    pulse(8'h12, 1'b0);
    repeat (4 * FBITS * CPB - 1) @(negedge clk);
    chk("last_stop_busy", busy, 1);
    pulse(8'h99, 1'b0);
    chk("last_stop_dropped_ovr", overrun, 1);
    chk("last_stop_idle", busy, 0);
    exp_lit = {8'h31, 8'h32, 8'h0D, 8'h0A};
    chk_rx("line_laststop");
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;

    pulse(8'h9E, 1'b0);
    wait_idle(n);
    chk("b2b_done", done, 1);
    pulse(8'h0B, 1'b0);
    chk("b2b_start_tx", tx, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_no_ovr", overrun, 0);
    wait_idle(n);
    exp_lit = {8'h39, 8'h45, 8'h0D, 8'h0A, 8'h30, 8'h42, 8'h0D, 8'h0A};
    chk_rx("line_b2b");

    pulse(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    rx_q.delete();
    exp_bytes.delete();

    for (int it = 0; it < 40; it++) begin
      pulse(8'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 200)) @(negedge clk);
        if ($urandom_range(0, 1) == 1) ovr_clr = 1'b1;
        pulse(8'($urandom), 1'($urandom_range(0, 1)));
        ovr_clr = 1'b0;
      end
      wait_idle(n);
      if ($urandom_range(0, 1) == 1) begin
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(n);
    repeat (5) @(negedge clk);
    chk("rand_rx_count", rx_q.size(), exp_bytes.size());
    foreach (exp_bytes[i]) chk("rand_rx_byte", (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_bytes[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/range_uart_reporter.md
# range_uart_reporter

Downstream consumer of the range-finder result. It captures each completed `range`/`error` result and transmits it as a short ASCII line over a single UART TX pin. Results go out as hex digits, or as `E` on error, followed by CR LF. At the top level it drives one `uio_out` pin so that results can be read by any serial terminal without a logic analyser.

## Interface

Parameters:
- `WIDTH`, default 8: result width; must be a multiple of 4; NCHARS = WIDTH/4 hex digits.
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (10 MHz / 115200); minimum 2.

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `res_valid`, input, 1: one-cycle pulse; `res_range` and `res_error` are valid this cycle.
- `res_range`, input, WIDTH: range value from the upstream range finder.
- `res_error`, input, 1: upstream error flag; takes priority over `res_range`.
- `ovr_clr`, input, 1: synchronous clear of `overrun`.
- `tx`, output, 1: UART serial out, idle high, 8 data bits LSB first, 1 stop bit.
- `busy`, output, 1: a message is being transmitted.
- `done`, output, 1: one-cycle pulse at the end of a message.
- `overrun`, output, 1: sticky flag; a result arrived while `busy`.

## Operation

- Message content:
  - `res_error`=0: NCHARS uppercase hex ASCII digits, MS nibble first (0–9 → 0x30–0x39, A–F → 0x41–0x46), then 0x0D, then 0x0A.
  - `res_error`=1: 0x45 ('E'), 0x0D, 0x0A. `res_range` is ignored.
- Capture:
  - `res_valid` while idle latches `res_range` and `res_error` into a holding register and starts the message.
  - `res_valid` while `busy`: the result is dropped, `overrun` is set, and the message in flight is unaffected.
- State machine (bit level): IDLE → START → DATA (8 bits) → [PARITY] → STOP.
  - After STOP, the machine goes to START if characters remain, otherwise to IDLE.
  - A per-bit counter counts 0..CLKS_PER_BIT-1, a bit index counts 0..7, and a character index counts 0..NCHARS+1 (0..2 on error).
- Characters within a message are sent back-to-back, with no idle time between a stop bit and the next start bit.
- `ovr_clr` clears `overrun`. If `ovr_clr` and a dropped `res_valid` occur in the same cycle, set wins.
- Reset values: `tx`=1, `busy`=0, `done`=0, `overrun`=0, state IDLE, holding register 0.
- Reset mid-message: `tx` returns high immediately (asynchronous). The partial frame is abandoned and no `done` is issued.

## Timing

- `res_valid` sampled high at edge N: `busy`=1 and `tx`=0 (start bit) from edge N, so visible in cycle N+1.
- Each bit holds for exactly CLKS_PER_BIT cycles. A character is 10 bits, or 11 with parity.
- Message length:
  - Normal: (NCHARS+2)·10·CLKS_PER_BIT cycles.
  - Error: 3·10·CLKS_PER_BIT cycles.
- `done` is high for exactly the one cycle in which `busy` falls and `tx` is back at its idle level.
- A `res_valid` in that same cycle (`busy` already 0) is accepted and starts a new message.
- A `res_valid` in the last cycle of the stop bit (`busy` still 1) is dropped and counted as an overrun.

## Configuration

- `RANGE_TX_PARITY_EN` defined: an even-parity bit is inserted between data bit 7 and the stop bit. It makes the count of ones across the data and parity bits even. Frame is 11 bits.
- Not defined: no parity state and 10-bit frames; the logic is absent from the netlist.

## Structure

- Shared package `range_pkg`:
  - ASCII constants `ASCII_CR`, `ASCII_LF`, `ASCII_E`.
  - The bit-state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - A `hex_to_ascii` function.
- One sub-module, `uart_tx_byte`: a byte serializer with `start`, `data[7:0]`, `tx`, and `ready`, plus the bit counter and parity logic.
- `range_uart_reporter` owns the capture register, character sequencing, `done`/`overrun`, and the message-level `busy`.

## Test plan

Run the bench with CLKS_PER_BIT=4 and WIDTH=8.

- Reset release with no input → `tx`=1, `busy`=0, `done`=0, `overrun`=0 held indefinitely.
- `res_valid` with `res_range`=0x3A and `res_error`=0 → line decodes to 0x33, 0x41, 0x0D, 0x0A; `busy` high for 160 cycles; single `done` pulse on cycle 161.
- `res_valid` with `res_error`=1 and `res_range`=0xFF → 0x45, 0x0D, 0x0A; 120 cycles; no hex digits sent.
- Second `res_valid` 50 cycles into the message → first line completes unchanged; `overrun`=1 until `ovr_clr`, then 0; second result never transmitted.
- `res_valid` in the `done` cycle → next start bit begins the following cycle; the two lines are back-to-back and both are correct.
- `rst_n` low mid-DATA → `tx`=1 and `busy`=0 immediately; no `done`.
- With `RANGE_TX_PARITY_EN` defined, range 0x3A → 0x33 (parity 0), 0x41 (parity 0), 0x0D (parity 1), 0x0A (parity 0); 176 cycles.
